// File: rtl/hazard_ctrl_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_ex_mem_read;
  logic                  id_ex_reg_write;
  logic [REG_ADDR_W-1:0] id_ex_dest_reg;
  logic                  ex_mem_mem_read;
  logic [REG_ADDR_W-1:0] ex_mem_dest_reg;
  logic [REG_ADDR_W-1:0] if_id_rs;
  logic [REG_ADDR_W-1:0] if_id_rt;
  logic                  if_id_uses_rs;
  logic                  if_id_uses_rt;
  logic                  if_id_is_branch;
  logic                  branch_taken;
  logic                  jump;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  ctrl_zero;
  logic                  if_id_flush;
  logic                  pipe_freeze;
  logic                  stall_active;

  modport master (
    output id_ex_mem_read, id_ex_reg_write, id_ex_dest_reg, ex_mem_mem_read,
           ex_mem_dest_reg, if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt,
           if_id_is_branch, branch_taken, jump, mem_ready,
    input  pc_write, if_id_write, ctrl_zero, if_id_flush, pipe_freeze, stall_active
  );

  modport slave (
    input  id_ex_mem_read, id_ex_reg_write, id_ex_dest_reg, ex_mem_mem_read,
           ex_mem_dest_reg, if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt,
           if_id_is_branch, branch_taken, jump, mem_ready,
    output pc_write, if_id_write, ctrl_zero, if_id_flush, pipe_freeze, stall_active
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Multi-cycle load-use / branch hazard controller with flush and memory freeze.
// Optional statistics counters are enabled by defining HAZ_STATS_EN.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_unit_if.slave hz
`ifdef HAZ_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] flush_count
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 7 || STAT_W < 1) begin : g_bad_param
    $error("hazard_ctrl_unit: LOAD_LAT must be 1..7 and STAT_W >= 1");
  end

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [3:0]            LAT      = 4'(LOAD_LAT);
  localparam logic [3:0]            LAT_P1   = 4'(LOAD_LAT + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       match_ex, match_mem;
  logic [3:0] n_req;
  logic       pc_write, if_id_write, ctrl_zero, if_id_flush, pipe_freeze, stall_active;

  assign match_ex  = (hz.if_id_uses_rs && hz.if_id_rs != REG_ZERO && hz.if_id_rs == hz.id_ex_dest_reg) ||
                     (hz.if_id_uses_rt && hz.if_id_rt != REG_ZERO && hz.if_id_rt == hz.id_ex_dest_reg);
  assign match_mem = (hz.if_id_uses_rs && hz.if_id_rs != REG_ZERO && hz.if_id_rs == hz.ex_mem_dest_reg) ||
                     (hz.if_id_uses_rt && hz.if_id_rt != REG_ZERO && hz.if_id_rt == hz.ex_mem_dest_reg);

  // Largest applicable stall length wins.
  always_comb begin
    n_req = 4'd0;
    if (hz.id_ex_mem_read && match_ex && LAT > n_req)
      n_req = LAT;
    if (hz.if_id_is_branch && hz.id_ex_reg_write && !hz.id_ex_mem_read && match_ex && n_req < 4'd1)
      n_req = 4'd1;
    if (hz.if_id_is_branch && hz.id_ex_mem_read && match_ex && LAT_P1 > n_req)
      n_req = LAT_P1;
    if (hz.if_id_is_branch && hz.ex_mem_mem_read && match_mem && LAT > n_req)
      n_req = LAT;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    ctrl_zero    = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    stall_active = 1'b0;
    if (!reset) begin
      stall_active = (state_reg == STALL) || (n_req != 4'd0);
      if (!hz.mem_ready) begin
        // Freeze holds state and count; the stall resumes where it left off.
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (state_reg == STALL) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ctrl_zero   = 1'b1;
        if (cnt_reg == 3'd1) begin
          state_next = RUN;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end else if (n_req != 4'd0) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ctrl_zero   = 1'b1;
        if (n_req > 4'd1) begin
          state_next = STALL;
          cnt_next   = 3'(n_req - 4'd1);
        end
      end else if ((hz.if_id_is_branch && hz.branch_taken) || hz.jump) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.ctrl_zero    = ctrl_zero;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.pipe_freeze  = pipe_freeze;
  assign hz.stall_active = stall_active;

`ifdef HAZ_STATS_EN
  // ctrl_zero is only high for a stall cycle that is not frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (ctrl_zero)
        stall_count <= stall_count + 1'b1;
      if (if_id_flush)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule
